// File: rtl/maze_pkg.sv
// Shared move codes, heading encoding and tracker state for the maze pose tracker.
package maze_pkg;

    localparam logic [2:0] MV_STOP  = 3'd0;
    localparam logic [2:0] MV_FWD   = 3'd1;
    localparam logic [2:0] MV_LEFT  = 3'd2;
    localparam logic [2:0] MV_RIGHT = 3'd3;
    localparam logic [2:0] MV_UTURN = 3'd4;

    typedef logic [1:0] heading_t;

    localparam heading_t HD_N = 2'd0;
    localparam heading_t HD_E = 2'd1;
    localparam heading_t HD_S = 2'd2;
    localparam heading_t HD_W = 2'd3;

    typedef enum logic [1:0] {
        ST_TRACK = 2'd0,
        ST_DONE  = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    // Heading rotation relies on natural 2-bit wrap.
    function automatic heading_t rotate(input heading_t h, input logic [1:0] delta);
        return heading_t'(h + delta);
    endfunction

endpackage

// File: rtl/maze_step_calc.sv
// Combinational next-cell calculation for one FORWARD step, with off-grid detection.
module maze_step_calc
    import maze_pkg::*;
(
    input  logic [3:0] row_i,
    input  logic [3:0] col_i,
    input  logic [1:0] heading_i,
    input  logic [4:0] rows_i,
    input  logic [4:0] cols_i,
    output logic [3:0] next_row_o,
    output logic [3:0] next_col_o,
    output logic       off_grid_o
);

    logic last_row_s;
    logic last_col_s;

    assign last_row_s = ({1'b0, row_i} == (rows_i - 5'd1));
    assign last_col_s = ({1'b0, col_i} == (cols_i - 5'd1));

    // Move one cell along the heading unless that would leave the grid.
    always_comb begin
        next_row_o = row_i;
        next_col_o = col_i;
        off_grid_o = 1'b0;
        case (heading_i)
            HD_N: begin
                if (row_i == 4'd0) begin
                    off_grid_o = 1'b1;
                end else begin
                    next_row_o = row_i - 4'd1;
                end
            end
            HD_S: begin
                if (last_row_s) begin
                    off_grid_o = 1'b1;
                end else begin
                    next_row_o = row_i + 4'd1;
                end
            end
            HD_E: begin
                if (last_col_s) begin
                    off_grid_o = 1'b1;
                end else begin
                    next_col_o = col_i + 4'd1;
                end
            end
            HD_W: begin
                if (col_i == 4'd0) begin
                    off_grid_o = 1'b1;
                end else begin
                    next_col_o = col_i - 4'd1;
                end
            end
            default: begin
                off_grid_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/maze_pose_tracker.sv
// Dead-reckoning pose tracker for the maze explorer command stream.
// Optional pose trace outputs are enabled by defining MAZE_TRACE_EN.
module maze_pose_tracker
    import maze_pkg::*;
#(
    parameter int ROWS       = 9,
    parameter int COLS       = 9,
    parameter int START_ROW  = 4,
    parameter int START_COL  = 0,
    parameter int START_HEAD = 1,
    parameter int EXIT_ROW   = 4,
    parameter int EXIT_COL   = 8,
    parameter int STEP_W     = 8,
    parameter int DE_W       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        move,
    input  logic              move_valid,
    output logic [3:0]        row,
    output logic [3:0]        col,
    output logic [1:0]        heading,
    output logic [STEP_W-1:0] step_count,
    output logic [DE_W-1:0]   deadend_count,
    output logic              at_exit,
    output logic              off_grid_err,
`ifdef MAZE_TRACE_EN
    output logic              trace_valid,
    output logic [3:0]        trace_row,
    output logic [3:0]        trace_col,
    output logic [1:0]        trace_head,
`endif
    output logic              bad_cmd
);

    localparam logic [3:0] START_ROW_L  = 4'(START_ROW);
    localparam logic [3:0] START_COL_L  = 4'(START_COL);
    localparam heading_t   START_HEAD_L = heading_t'(START_HEAD);
    localparam logic [3:0] EXIT_ROW_L   = 4'(EXIT_ROW);
    localparam logic [3:0] EXIT_COL_L   = 4'(EXIT_COL);
    localparam logic [4:0] ROWS_L       = 5'(ROWS);
    localparam logic [4:0] COLS_L       = 5'(COLS);
    localparam logic [STEP_W-1:0] STEP_ONE = {{(STEP_W-1){1'b0}}, 1'b1};
    localparam logic [DE_W-1:0]   DE_ONE   = {{(DE_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [3:0]        row_q, row_d;
    logic [3:0]        col_q, col_d;
    heading_t          head_q, head_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [DE_W-1:0]   de_q, de_d;
    logic              at_exit_q, at_exit_d;
    logic              off_q, off_d;
    logic              bad_q, bad_d;
    logic              accepted_s;

    logic [3:0] next_row_s;
    logic [3:0] next_col_s;
    logic       off_grid_s;

    maze_step_calc u_step_calc (
        .row_i      (row_q),
        .col_i      (col_q),
        .heading_i  (head_q),
        .rows_i     (ROWS_L),
        .cols_i     (COLS_L),
        .next_row_o (next_row_s),
        .next_col_o (next_col_s),
        .off_grid_o (off_grid_s)
    );

    // Next-state decode; commands only act while tracking.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        head_d     = head_q;
        step_d     = step_q;
        de_d       = de_q;
        at_exit_d  = at_exit_q;
        off_d      = off_q;
        bad_d      = 1'b0;
        accepted_s = 1'b0;
        if ((state_q == ST_TRACK) && move_valid) begin
            case (move)
                MV_STOP: begin
                    accepted_s = 1'b0;
                end
                MV_FWD: begin
                    if (off_grid_s) begin
                        state_d = ST_ERROR;
                        off_d   = 1'b1;
                    end else begin
                        accepted_s = 1'b1;
                        row_d      = next_row_s;
                        col_d      = next_col_s;
                        step_d     = (&step_q) ? step_q : step_q + STEP_ONE;
                        if ((next_row_s == EXIT_ROW_L) && (next_col_s == EXIT_COL_L)) begin
                            state_d   = ST_DONE;
                            at_exit_d = 1'b1;
                        end else begin
                            state_d = ST_TRACK;
                        end
                    end
                end
                MV_LEFT: begin
                    accepted_s = 1'b1;
                    head_d     = rotate(head_q, 2'd3);
                end
                MV_RIGHT: begin
                    accepted_s = 1'b1;
                    head_d     = rotate(head_q, 2'd1);
                end
                MV_UTURN: begin
                    accepted_s = 1'b1;
                    head_d     = rotate(head_q, 2'd2);
                    de_d       = (&de_q) ? de_q : de_q + DE_ONE;
                end
                default: begin
                    bad_d = 1'b1;
                end
            endcase
        end else begin
            accepted_s = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_TRACK;
            row_q     <= START_ROW_L;
            col_q     <= START_COL_L;
            head_q    <= START_HEAD_L;
            step_q    <= '0;
            de_q      <= '0;
            at_exit_q <= 1'b0;
            off_q     <= 1'b0;
            bad_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            head_q    <= head_d;
            step_q    <= step_d;
            de_q      <= de_d;
            at_exit_q <= at_exit_d;
            off_q     <= off_d;
            bad_q     <= bad_d;
        end
    end

`ifdef MAZE_TRACE_EN
    logic       trace_valid_q;
    logic [3:0] trace_row_q;
    logic [3:0] trace_col_q;
    heading_t   trace_head_q;

    // Trace registers capture the new pose alongside each accepted motion command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trace_valid_q <= 1'b0;
            trace_row_q   <= START_ROW_L;
            trace_col_q   <= START_COL_L;
            trace_head_q  <= START_HEAD_L;
        end else begin
            trace_valid_q <= accepted_s;
            if (accepted_s) begin
                trace_row_q  <= row_d;
                trace_col_q  <= col_d;
                trace_head_q <= head_d;
            end
        end
    end

    assign trace_valid = trace_valid_q;
    assign trace_row   = trace_row_q;
    assign trace_col   = trace_col_q;
    assign trace_head  = trace_head_q;
`endif

    assign row           = row_q;
    assign col           = col_q;
    assign heading       = head_q;
    assign step_count    = step_q;
    assign deadend_count = de_q;
    assign at_exit       = at_exit_q;
    assign off_grid_err  = off_q;
    assign bad_cmd       = bad_q;

endmodule

// File: tb/tb_maze_pose_tracker.sv
// Directed self-checking bench for maze_pose_tracker with default parameters.
module tb_maze_pose_tracker;

    logic       clk;
    logic       rst_n;
    logic [2:0] move;
    logic       move_valid;
    logic [3:0] row;
    logic [3:0] col;
    logic [1:0] heading;
    logic [7:0] step_count;
    logic [3:0] deadend_count;
    logic       at_exit;
    logic       off_grid_err;
    logic       bad_cmd;

    int checks = 0;
    int errors = 0;

    maze_pose_tracker dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .move          (move),
        .move_valid    (move_valid),
        .row           (row),
        .col           (col),
        .heading       (heading),
        .step_count    (step_count),
        .deadend_count (deadend_count),
        .at_exit       (at_exit),
        .off_grid_err  (off_grid_err),
        .bad_cmd       (bad_cmd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic [2:0] m, input logic v);
        @(negedge clk);
        move       = m;
        move_valid = v;
        @(posedge clk);
        #1;
        move_valid = 1'b0;
        move       = 3'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic check_pose(input string tag, input logic [3:0] r, input logic [3:0] c,
                              input logic [1:0] h, input logic [7:0] s, input logic [3:0] d);
        check({tag, ".row"}, 32'(row), 32'(r));
        check({tag, ".col"}, 32'(col), 32'(c));
        check({tag, ".head"}, 32'(heading), 32'(h));
        check({tag, ".steps"}, 32'(step_count), 32'(s));
        check({tag, ".deadends"}, 32'(deadend_count), 32'(d));
    endtask

    initial begin
        rst_n      = 1'b0;
        move       = 3'd0;
        move_valid = 1'b0;
        #12;
        check_pose("reset", 4'd4, 4'd0, 2'd1, 8'd0, 4'd0);
        check("reset.at_exit", 32'(at_exit), 32'd0);
        check("reset.off_grid", 32'(off_grid_err), 32'd0);
        check("reset.bad_cmd", 32'(bad_cmd), 32'd0);
        rst_n = 1'b1;

        // Eastward run to the exit.
        for (int i = 1; i <= 8; i++) begin
            cmd(3'd1, 1'b1);
            check("east.col", 32'(col), 32'(i));
            check("east.steps", 32'(step_count), 32'(i));
            check("east.at_exit", 32'(at_exit), (i == 8) ? 32'd1 : 32'd0);
        end
        cmd(3'd1, 1'b1);
        check_pose("after_exit", 4'd4, 4'd8, 2'd1, 8'd8, 4'd0);
        check("after_exit.at_exit", 32'(at_exit), 32'd1);
        cmd(3'd7, 1'b1);
        check("done_ignores_bad", 32'(bad_cmd), 32'd0);

        // South run off the bottom edge.
        do_reset();
        cmd(3'd3, 1'b1);
        check("south.head", 32'(heading), 32'd2);
        for (int i = 1; i <= 5; i++) begin
            cmd(3'd1, 1'b1);
            check("south.row", 32'(row), (i < 5) ? 32'(4 + i) : 32'd8);
            check("south.off_grid", 32'(off_grid_err), (i == 5) ? 32'd1 : 32'd0);
        end
        check_pose("offgrid", 4'd8, 4'd0, 2'd2, 8'd4, 4'd0);
        cmd(3'd2, 1'b1);
        check("error_frozen.head", 32'(heading), 32'd2);
        check("error_sticky", 32'(off_grid_err), 32'd1);

        // Four lefts cycle the heading back to east.
        do_reset();
        cmd(3'd2, 1'b1); check("left1.head", 32'(heading), 32'd0);
        cmd(3'd2, 1'b1); check("left2.head", 32'(heading), 32'd3);
        cmd(3'd2, 1'b1); check("left3.head", 32'(heading), 32'd2);
        cmd(3'd2, 1'b1);
        check_pose("left4", 4'd4, 4'd0, 2'd1, 8'd0, 4'd0);

        // Dead-end counter saturation.
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            cmd(3'd4, 1'b1);
            check("uturn.head", 32'(heading), (i % 2 == 1) ? 32'd3 : 32'd1);
            check("uturn.count", 32'(deadend_count), (i < 15) ? 32'(i) : 32'd15);
        end

        // Bad code pulse and invalid-qualified move.
        do_reset();
        cmd(3'd6, 1'b1);
        check("bad.pulse", 32'(bad_cmd), 32'd1);
        check_pose("bad", 4'd4, 4'd0, 2'd1, 8'd0, 4'd0);
        cmd(3'd0, 1'b0);
        check("bad.cleared", 32'(bad_cmd), 32'd0);
        cmd(3'd1, 1'b0);
        check_pose("novalid", 4'd4, 4'd0, 2'd1, 8'd0, 4'd0);
        cmd(3'd0, 1'b1);
        check_pose("stop", 4'd4, 4'd0, 2'd1, 8'd0, 4'd0);

        // Asynchronous reset in the middle of a run.
        do_reset();
        for (int i = 1; i <= 5; i++) cmd(3'd1, 1'b1);
        check_pose("mid", 4'd4, 4'd5, 2'd1, 8'd5, 4'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_pose("async_rst", 4'd4, 4'd0, 2'd1, 8'd0, 4'd0);
        check("async_rst.at_exit", 32'(at_exit), 32'd0);
        #1;
        rst_n = 1'b1;
        cmd(3'd1, 1'b1);
        check_pose("post_rst", 4'd4, 4'd1, 2'd1, 8'd1, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/maze_pose_tracker.md
Name: maze_pose_tracker

Overview:
- Sits directly downstream of the maze explorer FSM.
- Consumes its 3-bit move command stream and dead-reckons the bot's cell position and heading on the ROWSxCOLS grid.
- Counts steps and dead-ends (U-turns), flags exit arrival, and flags illegal off-grid moves.
- Outputs feed the score/debug logic and the top-level done indication.

Parameters:
ROWS, 9, grid rows (max 16)
COLS, 9, grid columns (max 16)
START_ROW, 4, reset row
START_COL, 0, reset column
START_HEAD, 1, reset heading (0=N,1=E,2=S,3=W)
EXIT_ROW, 4, exit cell row
EXIT_COL, 8, exit cell column
STEP_W, 8, step counter width
DE_W, 4, dead-end counter width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
move  in  3  command: 0 STOP, 1 FORWARD, 2 LEFT, 3 RIGHT, 4 U_TURN
move_valid  in  1  move is sampled on a rising clk edge when high
row  out  4  current row
col  out  4  current column
heading  out  2  current heading
step_count  out  STEP_W  accepted FORWARD count
deadend_count  out  DE_W  accepted U_TURN count
at_exit  out  1  sticky: exit cell reached
off_grid_err  out  1  sticky: FORWARD would leave the grid
bad_cmd  out  1  one-cycle pulse on codes 5-7

Behaviour:
- Reset is asynchronous, active-low, on rst_n.
- Reset values: row=START_ROW, col=START_COL, heading=START_HEAD, counters=0, at_exit=0, off_grid_err=0, bad_cmd=0, state=TRACK.
- An rst_n assertion mid-run returns everything to these values immediately, independent of clk.
- Latency: all outputs are registered and reflect a command one cycle after it is sampled.
- Commands are processed only when move_valid=1; with move_valid=0, nothing changes.
- State machine has three states:
  - TRACK: the only state that processes commands.
  - DONE: entered when FORWARD lands on (EXIT_ROW, EXIT_COL). at_exit=1; all further commands are ignored, including bad_cmd detection.
  - ERROR: entered when FORWARD would leave the grid. off_grid_err=1; pose is frozen at the last legal cell; all further commands are ignored.
  - Exit from DONE or ERROR is by reset only.
- Command effects in TRACK:
  - FORWARD: N row-1, S row+1, E col+1, W col-1.
  - LEFT: heading=(heading+3) mod 4; no cell change.
  - RIGHT: heading=(heading+1) mod 4; no cell change.
  - U_TURN: heading=(heading+2) mod 4; deadend_count+1.
  - STOP: no change.
  - Codes 5-7: no pose change; bad_cmd high for exactly the next cycle.
- Off-grid test: row=0 and heading N; row=ROWS-1 and heading S; col=0 and heading W; col=COLS-1 and heading E. An off-grid FORWARD does not increment step_count.
- Counter widths: step_count and deadend_count saturate at all-ones and never wrap.
- Simultaneous events:
  - A FORWARD that both enters the exit and saturates step_count applies both results.
  - The start cell is never treated as the exit, even if the parameters make them equal. DONE requires a FORWARD.
- Heading arithmetic is 2-bit modulo; wrap is natural.

Optional Feature:
- Macro: MAZE_TRACE_EN.
- Defined: adds outputs trace_valid (1), trace_row (4), trace_col (4) and trace_head (2).
  - trace_valid pulses for one cycle, coincident with the pose update, for every accepted FORWARD/LEFT/RIGHT/U_TURN.
  - trace_row, trace_col and trace_head carry the new pose.
  - trace_valid resets to 0.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Decomposition:
- Package maze_pkg:
  - move code localparams (MV_STOP..MV_UTURN)
  - heading typedef/constants (HD_N, HD_E, HD_S, HD_W)
  - tracker state enum (ST_TRACK, ST_DONE, ST_ERROR)
- One combinational sub-module, maze_step_calc:
  - inputs: row, col, heading, grid dims
  - outputs: next_row, next_col, off_grid
- Top module holds the FSM, counters and flags.

Test Plan:
- Reset, then 8x FORWARD with heading E -> col steps 1..8, at_exit=1 after 8th, step_count=8; a 9th FORWARD is ignored (col stays 8).
- RIGHT, then 5x FORWARD from (4,0) -> heading=2, row 5..8; the 5th FORWARD gives off_grid_err=1, row=8, step_count=4.
- LEFT, LEFT, LEFT, LEFT -> heading cycles 0,3,2,1; pose unchanged, step_count=0.
- 20x U_TURN -> deadend_count saturates at 15; heading alternates 3,1.
- move=6 with move_valid=1 -> bad_cmd high for exactly one cycle; pose and counters unchanged. move=1 with move_valid=0 -> no change.
- Assert rst_n low asynchronously mid-FORWARD sequence at (4,5) -> outputs return to (4,0), E, counts 0 before the next clk edge.
